seq_divider: RTL and testbench

//  Iterative restoring divider, the inverse of the team's 7x7 approximate multiplier.

---
 rtl/seq_divider.sv | 126 ++++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define APPROX_DIV_EN to skip the low TRUNC_BITS quotient bits (shorter latency, truncated result).
module seq_divider #(
  parameter int DIVIDEND_W = 14,
  parameter int DIVISOR_W  = 7,
  parameter int TRUNC_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef APPROX_DIV_EN
  localparam int N_ITER = DIVIDEND_W - TRUNC_BITS;
`else
  localparam int N_ITER = DIVIDEND_W;
`endif
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] N_LOAD = CNT_W'(N_ITER);

  if (DIVIDEND_W < DIVISOR_W || TRUNC_BITS >= DIVIDEND_W) begin : g_param_check
    $error("seq_divider: illegal parameter combination");
  end

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The remainder after a step is always below the divisor, so DIVISOR_W bits hold it.
  function automatic logic [DIVISOR_W:0] restore_step(
    input logic [DIVISOR_W:0]   r_in,
    input logic [DIVISOR_W-1:0] d
  );
    logic [DIVISOR_W:0] dx;
    dx = {1'b0, d};
    if (r_in >= dx) restore_step = {1'b1, DIVISOR_W'(r_in - dx)};
    else            restore_step = {1'b0, r_in[DIVISOR_W-1:0]};
  endfunction

  logic [1:0]            state;
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  r_acc;
  logic [DIVIDEND_W-1:0] q_acc;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    r_shift;
  logic [DIVISOR_W:0]    step;
  logic [DIVIDEND_W-1:0] q_next;
  logic [DIVIDEND_W-1:0] q_final;

  always_comb begin
    r_shift = {r_acc, dvd_sr[DIVIDEND_W-1]};
    step    = restore_step(r_shift, dvs);
    q_next  = DIVIDEND_W'({q_acc, step[DIVISOR_W]});
`ifdef APPROX_DIV_EN
    q_final = q_next << TRUNC_BITS;
`else
    q_final = q_next;
`endif
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_sr      <= '0;
      dvs         <= '0;
      r_acc       <= '0;
      q_acc       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_sr <= dividend;
            dvs    <= divisor;
            r_acc  <= '0;
            q_acc  <= '0;
            cnt    <= N_LOAD;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd_sr <= dvd_sr << 1;
          r_acc  <= step[DIVISOR_W-1:0];
          q_acc  <= q_next;
          cnt    <= cnt - CNT_W'(1);
          // The last iteration publishes its result directly so DONE needs no extra cycle.
          if (cnt == CNT_W'(1)) begin
            quotient    <= q_final;
            remainder   <= step[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand-written corner sequences, random sweep.
module tb_seq_divider;
  localparam int DW = 14;
  localparam int SW = 7;
  localparam int TB = 4;
`ifdef APPROX_DIV_EN
  localparam int NLAT = DW - TB;
`else
  localparam int NLAT = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .TRUNC_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division on the bits the mode processes.
  task automatic model(input int a, input int b, output int q, output int r, output int dbz, output int lat);
    if (b == 0) begin
      q = (1 << DW) - 1; r = a % (1 << SW); dbz = 1; lat = 0;
    end else begin
`ifdef APPROX_DIV_EN
      q = ((a >> TB) / b) << TB; r = (a >> TB) % b;
`else
      q = a / b; r = a % b;
`endif
      dbz = 0; lat = NLAT;
    end
  endtask

  // Runs one transaction; holds out_ready low for `hold` cycles in DONE and pokes in_valid meanwhile.
  task automatic run_div(input string tag, input int a, input int b, input int hold,
                         output int q, output int r, output int dbz, output int lat);
    int guard, busy_ready;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    dividend = DW'(a); divisor = SW'(b); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = DW'($urandom); divisor = SW'($urandom);
    lat = 0; busy_ready = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ready++;
      @(posedge clk); #1; lat++;
    end
    check({tag, " in_ready_busy"}, busy_ready, 0);
    q = quotient; r = remainder; dbz = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = DW'($urandom); divisor = SW'($urandom);
      @(posedge clk); #1;
      check({tag, " hold_valid"}, {31'd0, out_valid}, 1);
      check({tag, " hold_q"}, quotient, q);
      check({tag, " hold_r"}, remainder, r);
      check({tag, " hold_in_ready"}, {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release_valid"}, {31'd0, out_valid}, 0);
    check({tag, " release_in_ready"}, {31'd0, in_ready}, 1);
    check({tag, " release_q_kept"}, quotient, q);
  endtask

  typedef struct {
    int a; int b; int q; int r; int dbz; int lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int q, r, dbz, lat, eq, er, edbz, elat, ex_q;
`ifdef APPROX_DIV_EN
    tbl[0] = '{200, 7, 16, 5, 0, 10};
    tbl[1] = '{16383, 127, 128, 7, 0, 10};
    tbl[2] = '{16383, 1, 16368, 0, 0, 10};
    tbl[3] = '{5, 9, 0, 0, 0, 10};
    tbl[4] = '{100, 0, 16383, 100, 1, 0};
`else
    tbl[0] = '{200, 7, 28, 4, 0, 14};
    tbl[1] = '{16383, 127, 129, 0, 0, 14};
    tbl[2] = '{16383, 1, 16383, 0, 0, 14};
    tbl[3] = '{5, 9, 0, 5, 0, 14};
    tbl[4] = '{100, 0, 16383, 100, 1, 0};
`endif

    #1;
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 1);

    for (int i = 0; i < 5; i++) begin
      run_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, (i == 0) ? 5 : 0, q, r, dbz, lat);
      check($sformatf("vec%0d_q", i), q, tbl[i].q);
      check($sformatf("vec%0d_r", i), r, tbl[i].r);
      check($sformatf("vec%0d_dbz", i), dbz, tbl[i].dbz);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Reset during the sixth iteration of a division.
    @(negedge clk);
    dividend = 14'd200; divisor = 7'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", {31'd0, in_ready}, 1);
    run_div("after_rst", 81, 9, 0, q, r, dbz, lat);
    model(81, 9, eq, er, edbz, elat);
    check("after_rst_q", q, eq);
    check("after_rst_r", r, er);
    check("after_rst_lat", lat, elat);

    for (int i = 0; i < 150; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << DW) - 1));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, (1 << SW) - 1));
      run_div("rnd", a, b, int'($urandom_range(0, 2)), q, r, dbz, lat);
      model(a, b, eq, er, edbz, elat);
      check($sformatf("rnd%0d_q %0d/%0d", i, a, b), q, eq);
      check($sformatf("rnd%0d_r %0d/%0d", i, a, b), r, er);
      check($sformatf("rnd%0d_dbz", i), dbz, edbz);
      check($sformatf("rnd%0d_lat", i), lat, elat);
`ifdef APPROX_DIV_EN
      if (b != 0) begin
        ex_q = a / b;
        check($sformatf("rnd%0d_le_exact", i), {31'd0, q <= ex_q}, 1);
        check($sformatf("rnd%0d_err_bound", i), {31'd0, (ex_q - q) < (1 << TB)}, 1);
      end
`else
      ex_q = 0;
      if (b != 0) check($sformatf("rnd%0d_invariant", i), q * b + r, a + ex_q);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
